hash_query_ctrl: RTL and testbench
==================================

Name: hash_query_ctrl

Overview:
Initiator side of the hash table query interface. It accepts insert and lookup requests over a valid/ready handshake and hashes each value to a KEY_W-bit slot. It then drives INSERT_QUERY / LOOK_UP_QUERY transactions into hash_table, reading hash_table's 1-cycle-delayed resp. Collisions are resolved by linear probing, and a single result is returned per request on a valid/ready response channel.

Parameters:
KEY_W, 12, slot index width; table depth 2^KEY_W
VAL_W, 32, stored value width; value 0 is reserved as "empty"
MAX_PROBES, 8, max slots examined per request (1..2^KEY_W)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request ready
req_query_i  in  hash_query_t  INSERT_QUERY or LOOK_UP_QUERY
req_val_i  in  VAL_W  value to insert / look up
rsp_valid_o  out  1  result valid
rsp_ready_i  in  1  result accepted
rsp_hit_o  out  1  insert stored / lookup found
rsp_err_o  out  1  request had req_val_i == 0 (not executed)
rsp_key_o  out  KEY_W  slot written / slot matched (0 when !rsp_hit_o)
rsp_probes_o  out  $clog2(MAX_PROBES+1)  slots examined
tbl_wr_en_o  out  1  to hash_table wr_en_i
tbl_query_o  out  hash_query_t  to hash_query_i
tbl_wr_key_o  out  KEY_W  to hash_wr_key_i
tbl_rd_key_o  out  KEY_W  to hash_rd_key_i
tbl_val_o  out  VAL_W  to hash_val_i
tbl_resp_i  in  1  from resp_o

Behaviour:
- Reset is asynchronous on rst_n low. All outputs are 0, state is IDLE, and req_ready_o = 0 while in reset.
- Hash: the base key is the XOR of the ceil(VAL_W/KEY_W) KEY_W-bit slices of the value, with the top slice zero-padded. For the defaults: v[11:0] ^ v[23:12] ^ {4'h0, v[31:24]}.
- FSM states: IDLE, QUERY, WAIT, WRITE, DONE.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i, latch query, value, base key, and set probe count to 0.
  - If value == 0, go to DONE with rsp_err_o = 1, rsp_hit_o = 0, rsp_probes_o = 0.
  - Otherwise go to QUERY.
- QUERY (1 cycle):
  - tbl_rd_key_o = current key, tbl_query_o = latched query, tbl_val_o = latched value.
  - Increment probe count. Go to WAIT.
- WAIT:
  - Sample tbl_resp_i; it is valid this cycle because hash_table registers the query/value and BRAM read.
  - Insert with resp = 1 (slot empty): go to WRITE.
  - Lookup with resp = 1 (match): record key, set hit = 1, go to DONE.
  - resp = 0 and probe count < MAX_PROBES: key = key + 1 mod 2^KEY_W (wrap 2^KEY_W-1 to 0), go to QUERY.
  - resp = 0 and probe count == MAX_PROBES: set hit = 0, go to DONE.
- WRITE (1 cycle):
  - tbl_wr_en_o = 1, tbl_wr_key_o = current key, tbl_val_o = value.
  - Set hit = 1, go to DONE.
- DONE:
  - rsp_valid_o = 1; all rsp_* are held stable until rsp_ready_i, then go to IDLE.
  - req_ready_o = 0 in every non-IDLE state.
- tbl_val_o and tbl_query_o hold the latched request in all non-IDLE states; in IDLE they are 0.
- tbl_wr_en_o is 1 only in WRITE.
- Latency from the req accept edge to rsp_valid_o:
  - insert hit on probe n: 2n + 2 cycles;
  - lookup hit on probe n: 2n + 1 cycles;
  - failure: 2·MAX_PROBES + 1 cycles;
  - error: 1 cycle.
- A duplicate insert is not detected; it stores a second copy in the next empty slot.
- A lookup does not stop early at an empty slot; it probes up to MAX_PROBES slots.
- Reset asserted mid-operation returns to IDLE immediately. Any in-flight write is dropped, because tbl_wr_en_o is forced to 0.

Optional Feature:
HASH_CTRL_STATS_EN:
- When defined, adds four 16-bit outputs: stat_ins_ok_o, stat_ins_fail_o, stat_lkp_hit_o, stat_lkp_miss_o.
- Each counter increments once on the DONE handshake (rsp_valid_o & rsp_ready_i) for its outcome. Error requests are not counted.
- Counters saturate at 16'hFFFF and reset to 0.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Insert 32'h0000_0123 into an empty table -> tbl_rd_key_o = 12'h123 in QUERY; tbl_wr_en_o with tbl_wr_key_o = 12'h123; response hit = 1, key = 12'h123, probes = 1, rsp_valid_o 4 cycles after accept.
- Lookup 32'h0000_0123 after that insert -> hit = 1, key = 12'h123, probes = 1, rsp_valid_o 3 cycles after accept.
- Insert 32'h0000_0123 then 32'h0012_3000 (both hash to 12'h123) -> the second insert gives hit = 1, key = 12'h124, probes = 2.
- Fill slots 12'hFFF through 12'h006 with values hashing to 12'hFFF, then insert one more -> probe keys wrap FFF, 000, ..., 006; response hit = 0, probes = 8, no tbl_wr_en_o.
- req_val_i = 0 -> rsp_err_o = 1, hit = 0, no tbl_* activity. Hold rsp_ready_i = 0 for 5 cycles -> response stable and req_ready_o = 0 throughout.
- Assert rst_n low during WAIT of an insert -> all outputs 0 asynchronously; after release req_ready_o = 1; a following lookup of the same value misses (hit = 0, probes = 8).

Source files
------------

// File: rtl/hash_query_ctrl.sv
// hash_query_ctrl: hashes requests and runs linear-probe insert/lookup against
// hash_table. Ports: req_* in, rsp_* out, tbl_* to/from hash_table. Opt: HASH_CTRL_STATS_EN.
package hash_pkg;
  typedef enum logic {
    INSERT_QUERY  = 1'b0,
    LOOK_UP_QUERY = 1'b1
  } hash_query_t;
endpackage

module hash_query_ctrl
  import hash_pkg::*;
#(
  parameter int KEY_W      = 12,
  parameter int VAL_W      = 32,
  parameter int MAX_PROBES = 8,
  parameter int PW         = $clog2(MAX_PROBES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  hash_query_t       req_query_i,
  input  logic [VAL_W-1:0]  req_val_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_hit_o,
  output logic              rsp_err_o,
  output logic [KEY_W-1:0]  rsp_key_o,
  output logic [PW-1:0]     rsp_probes_o,
`ifdef HASH_CTRL_STATS_EN
  output logic [15:0]       stat_ins_ok_o,
  output logic [15:0]       stat_ins_fail_o,
  output logic [15:0]       stat_lkp_hit_o,
  output logic [15:0]       stat_lkp_miss_o,
`endif
  output logic              tbl_wr_en_o,
  output hash_query_t       tbl_query_o,
  output logic [KEY_W-1:0]  tbl_wr_key_o,
  output logic [KEY_W-1:0]  tbl_rd_key_o,
  output logic [VAL_W-1:0]  tbl_val_o,
  input  logic              tbl_resp_i
);

  localparam int NSL = (VAL_W + KEY_W - 1) / KEY_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_QUERY = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // XOR-fold of KEY_W slices, top slice zero-padded
  function automatic logic [KEY_W-1:0] f_hash(
    input logic [VAL_W-1:0] v
  );
    logic [NSL*KEY_W-1:0] pad;
    logic [KEY_W-1:0]     h;
    pad = '0;
    pad[VAL_W-1:0] = v;
    h = '0;
    for (int s = 0; s < NSL; s++)
      h = h ^ pad[s*KEY_W +: KEY_W];
    return h;
  endfunction

  logic [2:0]       r_state;
  hash_query_t      r_query;
  logic [VAL_W-1:0] r_val;
  logic [KEY_W-1:0] r_key;
  logic [PW-1:0]    r_probes;
  logic             r_hit;
  logic             r_err;

  logic w_idle, w_query, w_wait, w_write, w_done;
  logic w_last;

  assign w_idle  = (r_state == S_IDLE);
  assign w_query = (r_state == S_QUERY);
  assign w_wait  = (r_state == S_WAIT);
  assign w_write = (r_state == S_WRITE);
  assign w_done  = (r_state == S_DONE);
  assign w_last  = (r_probes >= PW'(MAX_PROBES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_query  <= INSERT_QUERY;
      r_val    <= '0;
      r_key    <= '0;
      r_probes <= '0;
      r_hit    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      unique case (1'b1)
        w_idle: begin
          if (req_valid_i) begin
            r_query  <= req_query_i;
            r_val    <= req_val_i;
            r_key    <= f_hash(req_val_i);
            r_probes <= '0;
            r_hit    <= 1'b0;
            r_err    <= (req_val_i == '0);
            r_state  <= (req_val_i == '0) ? S_DONE : S_QUERY;
          end
        end
        w_query: begin
          r_probes <= r_probes + PW'(1);
          r_state  <= S_WAIT;
        end
        w_wait: begin
          if (tbl_resp_i) begin
            if (r_query == INSERT_QUERY) begin
              r_state <= S_WRITE;
            end else begin
              r_hit   <= 1'b1;
              r_state <= S_DONE;
            end
          end else if (!w_last) begin
            r_key   <= r_key + KEY_W'(1);
            r_state <= S_QUERY;
          end else begin
            r_hit   <= 1'b0;
            r_state <= S_DONE;
          end
        end
        w_write: begin
          r_hit   <= 1'b1;
          r_state <= S_DONE;
        end
        w_done: begin
          if (rsp_ready_i)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // rst_n gate keeps ready low while reset is held
  assign req_ready_o  = w_idle & rst_n;
  assign rsp_valid_o  = w_done;
  assign rsp_hit_o    = w_done & r_hit;
  assign rsp_err_o    = w_done & r_err;
  assign rsp_key_o    = (w_done & r_hit) ? r_key : '0;
  assign rsp_probes_o = w_done ? r_probes : '0;

  assign tbl_wr_en_o  = w_write;
  assign tbl_query_o  = w_idle ? INSERT_QUERY : r_query;
  assign tbl_val_o    = w_idle ? '0 : r_val;
  assign tbl_rd_key_o = w_query ? r_key : '0;
  assign tbl_wr_key_o = w_write ? r_key : '0;

`ifdef HASH_CTRL_STATS_EN
  logic [15:0] r_ins_ok, r_ins_fail;
  logic [15:0] r_lkp_hit, r_lkp_miss;
  logic        w_hs;

  assign w_hs = w_done & rsp_ready_i & ~r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ins_ok   <= '0;
      r_ins_fail <= '0;
      r_lkp_hit  <= '0;
      r_lkp_miss <= '0;
    end else if (w_hs) begin
      if (r_query == INSERT_QUERY) begin
        if (r_hit && r_ins_ok != 16'hFFFF)
          r_ins_ok <= r_ins_ok + 16'd1;
        if (!r_hit && r_ins_fail != 16'hFFFF)
          r_ins_fail <= r_ins_fail + 16'd1;
      end else begin
        if (r_hit && r_lkp_hit != 16'hFFFF)
          r_lkp_hit <= r_lkp_hit + 16'd1;
        if (!r_hit && r_lkp_miss != 16'hFFFF)
          r_lkp_miss <= r_lkp_miss + 16'd1;
      end
    end
  end

  assign stat_ins_ok_o   = r_ins_ok;
  assign stat_ins_fail_o = r_ins_fail;
  assign stat_lkp_hit_o  = r_lkp_hit;
  assign stat_lkp_miss_o = r_lkp_miss;
`endif

endmodule

// File: tb/tb_hash_query_ctrl.sv
// tb_hash_query_ctrl: directed + random requests against a behavioural
// hash_table stand-in, checked by a slot-array reference model.
module tb_hash_query_ctrl;
  import hash_pkg::*;

  localparam int MAXP = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  hash_query_t req_query_i = INSERT_QUERY;
  logic [31:0] req_val_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic        rsp_hit_o;
  logic        rsp_err_o;
  logic [11:0] rsp_key_o;
  logic [3:0]  rsp_probes_o;
  logic        tbl_wr_en_o;
  hash_query_t tbl_query_o;
  logic [11:0] tbl_wr_key_o;
  logic [11:0] tbl_rd_key_o;
  logic [31:0] tbl_val_o;
  logic        tbl_resp_i = 1'b0;
`ifdef HASH_CTRL_STATS_EN
  logic [15:0] s0, s1, s2, s3;
`endif

  int total = 0;
  int bad = 0;

  logic [31:0] tmem [0:4095] = '{default: '0};
  logic [31:0] ref_mem [0:4095] = '{default: '0};

  hash_query_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_query_i(req_query_i), .req_val_i(req_val_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_hit_o(rsp_hit_o), .rsp_err_o(rsp_err_o),
    .rsp_key_o(rsp_key_o), .rsp_probes_o(rsp_probes_o),
`ifdef HASH_CTRL_STATS_EN
    .stat_ins_ok_o(s0), .stat_ins_fail_o(s1),
    .stat_lkp_hit_o(s2), .stat_lkp_miss_o(s3),
`endif
    .tbl_wr_en_o(tbl_wr_en_o), .tbl_query_o(tbl_query_o),
    .tbl_wr_key_o(tbl_wr_key_o), .tbl_rd_key_o(tbl_rd_key_o),
    .tbl_val_o(tbl_val_o), .tbl_resp_i(tbl_resp_i)
  );

  always #5 clk = ~clk;

  // hash_table stand-in: registered query compare, 1-cycle resp
  always @(posedge clk) begin
    if (tbl_query_o == LOOK_UP_QUERY)
      tbl_resp_i <= (tmem[tbl_rd_key_o] == tbl_val_o);
    else
      tbl_resp_i <= (tmem[tbl_rd_key_o] == 32'h0);
    if (tbl_wr_en_o)
      tmem[tbl_wr_key_o] <= tbl_val_o;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int hsh(input logic [31:0] v);
    return int'(v & 32'hFFF) ^ int'((v >> 12) & 32'hFFF) ^ int'(v >> 24);
  endfunction

  task automatic model(input hash_query_t q, input logic [31:0] v,
                       output logic hit, output logic err,
                       output int key, output int probes,
                       output int lat, output int base);
    base = hsh(v);
    hit = 1'b0;
    err = (v == 32'h0);
    key = 0;
    probes = 0;
    lat = 1;
    if (err) return;
    probes = MAXP;
    lat = 2 * MAXP + 1;
    for (int i = 0; i < MAXP; i++) begin
      int k;
      logic m;
      k = (base + i) % 4096;
      m = (q == INSERT_QUERY) ? (ref_mem[k] == 32'h0)
                              : (ref_mem[k] == v);
      if (m) begin
        hit = 1'b1;
        key = k;
        probes = i + 1;
        lat = (q == INSERT_QUERY) ? 2 * (i + 1) + 2 : 2 * (i + 1) + 1;
        if (q == INSERT_QUERY) ref_mem[k] = v;
        break;
      end
    end
  endtask

  task automatic do_req(input hash_query_t q, input logic [31:0] v,
                        input int hold);
    logic e_hit, e_err;
    int e_key, e_pr, e_lat, base, n, cyc, wrc, wrk;
    model(q, v, e_hit, e_err, e_key, e_pr, e_lat, base);
    n = 0;
    while (!req_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", req_ready_o, 1);
    req_valid_i = 1'b1;
    req_query_i = q;
    req_val_i = v;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    cyc = 0;
    wrc = 0;
    wrk = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!e_err && cyc == 1) begin
        chk("q_val", tbl_val_o, v);
        chk("q_query", tbl_query_o, q);
      end
      if (!e_err && cyc % 2 == 1 && cyc <= 2 * e_pr - 1)
        chk("rd_key", tbl_rd_key_o, (base + (cyc - 1) / 2) % 4096);
      if (tbl_wr_en_o) begin
        wrc++;
        wrk = int'(tbl_wr_key_o);
      end
    end while (!rsp_valid_o && cyc < 60);
    chk("latency", cyc, e_lat);
    chk("hit", rsp_hit_o, e_hit);
    chk("err", rsp_err_o, e_err);
    chk("key", rsp_key_o, e_key);
    chk("probes", rsp_probes_o, e_pr);
    chk("wr_cnt", wrc, (q == INSERT_QUERY && e_hit) ? 1 : 0);
    if (wrc == 1) chk("wr_key", wrk, e_key);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid_o, 1);
      chk("hold_ready", req_ready_o, 0);
      chk("hold_hit", rsp_hit_o, e_hit);
      chk("hold_err", rsp_err_o, e_err);
      chk("hold_key", rsp_key_o, e_key);
      chk("hold_probes", rsp_probes_o, e_pr);
      chk("hold_wr", tbl_wr_en_o, 0);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    chk("rsp_drop", rsp_valid_o, 0);
  endtask

  initial begin
    #12;
    chk("rst_ready", req_ready_o, 0);
    chk("rst_valid", rsp_valid_o, 0);
    chk("rst_wr", tbl_wr_en_o, 0);
    chk("rst_val", tbl_val_o, 0);
    chk("rst_probes", rsp_probes_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", req_ready_o, 1);

    do_req(INSERT_QUERY, 32'h0000_0123, 0);
    do_req(LOOK_UP_QUERY, 32'h0000_0123, 0);
    do_req(INSERT_QUERY, 32'h0012_3000, 0);

    for (int i = 0; i < 9; i++)
      do_req(INSERT_QUERY, (32'(i) << 12) | (32'hFFF ^ 32'(i)), 0);
    do_req(LOOK_UP_QUERY, 32'h0000_7FF8, 0);

    do_req(INSERT_QUERY, 32'h0, 5);
    do_req(LOOK_UP_QUERY, 32'h0, 1);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] r, b, v;
      hash_query_t q;
      r = 32'($urandom_range(0, 15));
      b = ($urandom_range(0, 1) == 0) ? 32'h200 : 32'h201;
      v = (r << 12) | (b ^ r);
      if ($urandom_range(0, 9) == 0) v = 32'h0;
      q = ($urandom_range(0, 1) == 0) ? INSERT_QUERY : LOOK_UP_QUERY;
      do_req(q, v, $urandom_range(0, 2));
    end

    @(negedge clk);
    req_valid_i = 1'b1;
    req_query_i = INSERT_QUERY;
    req_val_i = 32'h0000_0456;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_ready", req_ready_o, 0);
    chk("mid_valid", rsp_valid_o, 0);
    chk("mid_wr", tbl_wr_en_o, 0);
    chk("mid_val", tbl_val_o, 0);
    chk("mid_query", tbl_query_o, 0);
    chk("mid_rdkey", tbl_rd_key_o, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", req_ready_o, 1);
    do_req(LOOK_UP_QUERY, 32'h0000_0456, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
